srl_trigger_cfg: RTL and testbench
==================================

Name: srl_trigger_cfg

Overview:
- Sequencer that loads mask/value match tables into the SRLC16E-based trigger match LUTs of the analyzer's trigger unit.
- Accepts one (term, mask, value) command per handshake.
- Expands each 4-bit input nibble into a 16-entry truth table and shifts it serially into the selected term's SRL bank over 16 cycles.
- Sits between the SUMP command decoder (upstream) and the trigger match SRL array (downstream).

Parameters:
- DW, 32, sampled input width; multiple of 4; one SRL per nibble, giving DW/4 SRLs per term.
- NTERMS, 4, number of trigger match terms (SRL banks); 1..16.
- TW, 2, width of the term index; must satisfy 2**TW >= NTERMS.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_term  in  TW  target term index.
- cmd_mask  in  DW  per-bit compare enable (1 = compare).
- cmd_value  in  DW  per-bit compare value.
- armed  in  1  trigger unit armed (used only with optional feature).
- srl_ce  out  NTERMS  one-hot shift enable to the SRL banks.
- srl_din  out  DW/4  serial data, one bit per nibble SRL, shared by all terms.
- busy  out  1  load in progress.
- done  out  1  single-cycle pulse when a command completes.
- cmd_err  out  1  asserted together with done when cmd_term >= NTERMS.

Behaviour:
- Reset values: cmd_ready=0 during the reset cycle and 1 from the first cycle after reset; srl_ce=0, srl_din=0, busy=0, done=0, cmd_err=0.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch term/mask/value, clear the 4-bit step counter, go to LOAD.
- LOAD: 16 cycles, step k = 0..15.
  - Table address addr = 15-k, so the first bit shifted ends at SRL location 15.
  - srl_din[n] = (((addr ^ value[4n+3:4n]) & mask[4n+3:4n]) == 0).
  - srl_ce[term] = 1; all other srl_ce bits = 0.
  - busy=1, cmd_ready=0.
  - After k=15, go to DONE.
- DONE: 1 cycle.
  - done=1, srl_ce=0, busy=0, cmd_ready=0.
  - Next state is IDLE.
- All outputs are registered.
- Latency: handshake in cycle 0 → srl_ce high in cycles 1..16 → done in cycle 17 → cmd_ready high again in cycle 18. Throughput is one command per 18 cycles.
- srl_din and srl_ce change together on the same edge. The downstream SRL samples them on the next edge; its internal CE/D delays are absorbed by this.
- Fully masked nibble (mask nibble=0): srl_din bit is 1 for all 16 steps, i.e. always match.
- Out-of-range term (cmd_term >= NTERMS): the full 18-cycle sequence still runs, but srl_ce stays all-zero. cmd_err=1 for the DONE cycle only.
- cmd_valid while not ready: ignored, no latching; the upstream block holds the command stable.
- Reset mid-LOAD: next cycle enters IDLE with srl_ce=0 and no done pulse. The partially shifted table is invalid and software must reissue the command.
- Inputs not latched into the command registers are ignored outside IDLE.

Optional Feature:
- Macro: SRL_TRIGGER_CFG_ARM_LOCK_EN.
- Defined: cmd_ready = IDLE & ~armed.
  - A command never starts while armed.
  - If armed rises during LOAD, the load completes normally.
- Undefined: armed is ignored and cmd_ready = IDLE.

Decomposition:
- Shared package trigger_cfg_pkg holds:
  - constant SRL_DEPTH=16 and NIBBLE=4;
  - the state enum {IDLE, LOAD, DONE};
  - a function nibble_match(addr, val, msk) returning 1 bit.
- One natural sub-module, srl_nibble_expand: combinational DW/4 instances of nibble_match over the current addr.
- The FSM and counter stay in srl_trigger_cfg.

Test Plan:
- Term 0, mask=0x0000000F, value=0x00000005.
  - srl_ce=4'b0001 for cycles 1..16.
  - srl_din[0]=1 only in cycle 11 (addr 5).
  - srl_din[7:1]=7'h7F throughout.
  - done pulses in cycle 17.
- Term 2, mask=0, value=0xFFFFFFFF → srl_ce=4'b0100 for 16 cycles, srl_din=8'hFF every cycle, cmd_err=0.
- Term 1, mask=0x000000F0, value=0x000000A0 → srl_din[1] high only at addr 10 (cycle 6). Using the captured 16 bits, model an SRLC16E and check that reading address 10 returns 1 and reading address 3 returns 0.
- Back-to-back commands with cmd_valid held high → second handshake in cycle 18, second srl_ce window in cycles 19..34, exactly two done pulses.
- Reset asserted in cycle 8 of a load → srl_ce=0 and busy=0 next cycle, no done pulse, cmd_ready=1 one cycle after reset deasserts.
- With SRL_TRIGGER_CFG_ARM_LOCK_EN: armed=1 with cmd_valid=1 → cmd_ready=0, no srl_ce activity; armed drops → handshake next cycle. Separately, cmd_term=4 with NTERMS=4 → srl_ce stays 0, cmd_err=1 with done in cycle 17.

Source files
------------

// File: rtl/trigger_cfg_pkg.sv
// Shared constants, FSM state type and nibble match helper for the trigger match LUT loader.
package trigger_cfg_pkg;

  localparam int unsigned SRL_DEPTH = 16;
  localparam int unsigned NIBBLE    = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  // One truth-table entry: addr matches when every compared bit equals the value bit.
  function automatic logic nibble_match(
    input logic [NIBBLE-1:0] addr,
    input logic [NIBBLE-1:0] val,
    input logic [NIBBLE-1:0] msk
  );
    return (((addr ^ val) & msk) == '0);
  endfunction

endpackage

// File: rtl/srl_nibble_expand.sv
// Evaluates the match truth table of every nibble of a term at a single table address.
module srl_nibble_expand
  import trigger_cfg_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [NIBBLE-1:0]    i_addr,
  input  logic [DW-1:0]        i_mask,
  input  logic [DW-1:0]        i_value,
  output logic [DW/NIBBLE-1:0] o_match
);

  for (genvar n = 0; n < DW/NIBBLE; n++) begin : g_nib
    assign o_match[n] = nibble_match(i_addr,
                                     i_value[n*NIBBLE +: NIBBLE],
                                     i_mask[n*NIBBLE +: NIBBLE]);
  end

endmodule

// File: rtl/srl_trigger_cfg.sv
// Serially loads mask/value match tables into the selected term's SRLC16E bank.
// Optional macro SRL_TRIGGER_CFG_ARM_LOCK_EN blocks new commands while the trigger is armed.
module srl_trigger_cfg
  import trigger_cfg_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned NTERMS = 4,
  parameter int unsigned TW     = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [TW-1:0]        cmd_term,
  input  logic [DW-1:0]        cmd_mask,
  input  logic [DW-1:0]        cmd_value,
  input  logic                 armed,
  output logic [NTERMS-1:0]    srl_ce,
  output logic [DW/NIBBLE-1:0] srl_din,
  output logic                 busy,
  output logic                 done,
  output logic                 cmd_err
);

  localparam logic [NIBBLE-1:0] LAST_STEP = NIBBLE'(SRL_DEPTH - 1);

  state_t              r_state;
  logic [NIBBLE-1:0]   r_cnt;
  logic [TW-1:0]       r_term;
  logic [DW-1:0]       r_mask;
  logic [DW-1:0]       r_value;
  logic                r_err;

  logic                w_accept;
  logic                w_ready_nxt;
  logic                w_in_load;
  logic [NIBBLE-1:0]   w_addr;
  logic [DW-1:0]       w_mask;
  logic [DW-1:0]       w_value;
  logic [DW/NIBBLE-1:0] w_match;
  logic [NTERMS-1:0]   w_ce_sel;
  logic                w_err_in;

  assign w_accept = cmd_valid & cmd_ready;

`ifdef SRL_TRIGGER_CFG_ARM_LOCK_EN
  assign w_ready_nxt = ~armed;
`else
  logic w_unused_armed;
  assign w_unused_armed = armed;
  assign w_ready_nxt    = 1'b1;
`endif

  // Outputs are registered, so the table bit for the step about to be presented
  // is computed one cycle early: address 15 from the live command on accept,
  // then 15-(k+1) from the latched command during LOAD.
  assign w_in_load = (r_state == LOAD);
  assign w_addr    = w_in_load ? ~(r_cnt + NIBBLE'(1)) : LAST_STEP;
  assign w_mask    = w_in_load ? r_mask  : cmd_mask;
  assign w_value   = w_in_load ? r_value : cmd_value;

  srl_nibble_expand #(
    .DW (DW)
  ) u_expand (
    .i_addr  (w_addr),
    .i_mask  (w_mask),
    .i_value (w_value),
    .o_match (w_match)
  );

  // An out-of-range term matches no bit, leaving every shift enable low.
  always_comb begin
    w_ce_sel = '0;
    for (int unsigned t = 0; t < NTERMS; t++) begin
      w_ce_sel[t] = (32'(cmd_term) == t);
    end
  end

  assign w_err_in = (32'(cmd_term) >= NTERMS);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_term    <= '0;
      r_mask    <= '0;
      r_value   <= '0;
      r_err     <= 1'b0;
      cmd_ready <= 1'b0;
      srl_ce    <= '0;
      srl_din   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;
      case (r_state)
        IDLE: begin
          cmd_ready <= w_ready_nxt;
          if (w_accept) begin
            r_term    <= cmd_term;
            r_mask    <= cmd_mask;
            r_value   <= cmd_value;
            r_err     <= w_err_in;
            r_cnt     <= '0;
            r_state   <= LOAD;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            srl_ce    <= w_ce_sel;
            srl_din   <= w_match;
          end
        end
        LOAD: begin
          if (r_cnt == LAST_STEP) begin
            r_state <= DONE;
            srl_ce  <= '0;
            srl_din <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            cmd_err <= r_err;
          end else begin
            r_cnt   <= r_cnt + NIBBLE'(1);
            srl_din <= w_match;
          end
        end
        DONE: begin
          r_state   <= IDLE;
          cmd_ready <= w_ready_nxt;
        end
        default: begin
          r_state   <= IDLE;
          cmd_ready <= 1'b0;
          srl_ce    <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srl_trigger_cfg.sv
// Scoreboard bench for srl_trigger_cfg: stimulus queues expected shift streams, a monitor pops and compares.
module tb_srl_trigger_cfg;

  localparam int unsigned DW = 32;
  localparam int unsigned NT = 4;
  localparam int unsigned TW = 3;
  localparam int unsigned NN = DW / 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            armed = 1'b0;
  logic [TW-1:0]   cmd_term = '0;
  logic [DW-1:0]   cmd_mask = '0;
  logic [DW-1:0]   cmd_value = '0;
  logic            cmd_ready;
  logic [NT-1:0]   srl_ce;
  logic [NN-1:0]   srl_din;
  logic            busy;
  logic            done;
  logic            cmd_err;

  srl_trigger_cfg #(
    .DW     (DW),
    .NTERMS (NT),
    .TW     (TW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_term  (cmd_term),
    .cmd_mask  (cmd_mask),
    .cmd_value (cmd_value),
    .armed     (armed),
    .srl_ce    (srl_ce),
    .srl_din   (srl_din),
    .busy      (busy),
    .done      (done),
    .cmd_err   (cmd_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int                  cyc;
    bit                  is_done;
    logic [NT-1:0]       ce;
    logic [NN-1:0]       din;
    bit                  err;
    int                  term;
    logic [NN-1:0][15:0] tab;
  } exp_t;

  exp_t q[$];
  logic [15:0] srl_mem [NT][NN];

  function automatic void check(input string name, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Truth table straight from the rule: address a matches when each compared bit equals the value bit.
  function automatic logic [15:0] ref_table(input logic [3:0] v, input logic [3:0] m);
    logic [15:0] t;
    logic [3:0]  av;
    bit          ok;
    for (int unsigned a = 0; a < 16; a++) begin
      av = 4'(a);
      ok = 1'b1;
      for (int unsigned b = 0; b < 4; b++) begin
        if (m[b] && (av[b] != v[b])) ok = 1'b0;
      end
      t[a] = ok;
    end
    return t;
  endfunction

  function automatic void push_cmd(input int hs, input logic [TW-1:0] t,
                                   input logic [DW-1:0] m, input logic [DW-1:0] v);
    exp_t r;
    logic [NT-1:0] ce;
    for (int unsigned n = 0; n < NN; n++) r.tab[n] = ref_table(v[n*4 +: 4], m[n*4 +: 4]);
    ce = '0;
    for (int unsigned i = 0; i < NT; i++) if (32'(t) == i) ce[i] = 1'b1;
    r.term = int'(t);
    r.err  = (32'(t) >= NT);
    for (int unsigned k = 0; k < 16; k++) begin
      r.cyc     = hs + 1 + int'(k);
      r.is_done = 1'b0;
      r.ce      = ce;
      for (int unsigned n = 0; n < NN; n++) r.din[n] = r.tab[n][15 - k];
      q.push_back(r);
    end
    r.cyc     = hs + 17;
    r.is_done = 1'b1;
    r.ce      = '0;
    r.din     = '0;
    q.push_back(r);
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      for (int unsigned t = 0; t < NT; t++)
        for (int unsigned n = 0; n < NN; n++) srl_mem[t][n] = '0;
    end else begin
      if (done) done_cnt++;
      if (busy || done) begin
        if (q.size() == 0) begin
          check("unexpected_output", {busy, done}, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("output_cycle", cyc, e.cyc);
          check("done_flag", done, e.is_done);
          if (e.is_done) begin
            check("cmd_err", cmd_err, e.err);
            check("ce_at_done", srl_ce, 0);
            if (e.term < int'(NT))
              for (int unsigned n = 0; n < NN; n++)
                check("srl_table", srl_mem[e.term][n], e.tab[n]);
          end else begin
            check("srl_ce", srl_ce, e.ce);
            check("srl_din", srl_din, e.din);
            check("ready_while_busy", cmd_ready, 0);
          end
        end
      end else begin
        if (srl_ce != '0) check("ce_while_idle", srl_ce, 0);
        if (cmd_err) check("err_without_done", cmd_err, 0);
      end
      // Downstream SRLC16E model: shift in at location 0, oldest bit ends at location 15.
      for (int unsigned t = 0; t < NT; t++)
        if (srl_ce[t])
          for (int unsigned n = 0; n < NN; n++)
            srl_mem[t][n] = {srl_mem[t][n][14:0], srl_din[n]};
    end
  end

  task automatic send(input logic [TW-1:0] t, input logic [DW-1:0] m, input logic [DW-1:0] v,
                      input bit keep, output int hs);
    int w;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_term  = t;
    cmd_mask  = m;
    cmd_value = v;
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(negedge clock);
      w++;
    end
    if (!cmd_ready) begin
      check("handshake_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      hs = -1;
    end else begin
      hs = cyc;
      push_cmd(hs, t, m, v);
      @(posedge clock);
      #1;
      if (!keep) cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 200) begin
      @(negedge clock);
      w++;
    end
    check("drain", q.size(), 0);
    @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, hs2, dc;
    logic [TW-1:0] t;
    logic [DW-1:0] m, v;

    // Reset state
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_srl_ce", srl_ce, 0);
    check("rst_srl_din", srl_din, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cmd_err", cmd_err, 0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", cmd_ready, 1);

    // Directed loads
    send(3'd0, 32'h0000_000F, 32'h0000_0005, 1'b0, hs);
    drain();
    send(3'd2, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, hs);
    drain();
    send(3'd1, 32'h0000_00F0, 32'h0000_00A0, 1'b0, hs);
    drain();
    check("srl_read_addr10", srl_mem[1][1][10], 1);
    check("srl_read_addr3", srl_mem[1][1][3], 0);

    // Back-to-back with cmd_valid held
    dc = done_cnt;
    send(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, hs);
    send(3'd0, 32'hF0F0_0F0F, 32'h5A5A_A5A5, 1'b0, hs2);
    check("b2b_handshake_gap", hs2 - hs, 18);
    drain();
    check("b2b_done_pulses", done_cnt - dc, 2);

    // Reset in the middle of a load
    send(3'd3, 32'hFFFF_FFFF, 32'h0123_4567, 1'b0, hs);
    while (cyc < hs + 8) @(negedge clock);
    dc = done_cnt;
    reset = 1'b1;
    q.delete();
    @(negedge clock);
    check("midrst_srl_ce", srl_ce, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_ready", cmd_ready, 1);
    repeat (20) @(negedge clock);
    check("midrst_no_done", done_cnt - dc, 0);

    // Out-of-range terms
    send(3'd4, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, hs);
    drain();
    send(3'd7, 32'h0000_0000, 32'h0000_0000, 1'b0, hs);
    drain();

`ifdef SRL_TRIGGER_CFG_ARM_LOCK_EN
    // Arm lock: no command starts while armed
    @(negedge clock);
    armed = 1'b1;
    repeat (2) @(negedge clock);
    cmd_valid = 1'b1;
    cmd_term  = 3'd0;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clock);
      check("armed_ready", cmd_ready, 0);
      check("armed_busy", busy, 0);
    end
    armed = 1'b0;
    dc = cyc;
    send(3'd0, 32'h0000_0FF0, 32'h0000_0320, 1'b0, hs);
    check("arm_release_latency", hs - dc, 1);
    drain();
`endif

    // Randomized commands
    for (int unsigned i = 0; i < 24; i++) begin
      t = TW'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       m = '0;
        1:       m = '1;
        2:       m = $urandom & $urandom;
        default: m = $urandom;
      endcase
      v = $urandom;
`ifndef SRL_TRIGGER_CFG_ARM_LOCK_EN
      armed = 1'($urandom_range(0, 1));
`endif
      send(t, m, v, (i != 23) && ($urandom_range(0, 1) == 1), hs);
    end
    drain();
    armed = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
